// File: rtl/nibble_sorter.sv
// nibble_sorter: buffers N_ELEM operands, bubble-sorts them through an
// external less-than comparator and streams the sorted batch out.
module nibble_sorter #(
  parameter int N_ELEM = 4,
  parameter int W      = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] cmp_a,
  output logic [W-1:0] cmp_b,
  input  logic         cmp_lt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  localparam int IW = $clog2(N_ELEM);
  localparam logic [IW-1:0] LAST  = IW'(N_ELEM - 1);
  localparam logic [IW-1:0] LASTP = IW'(N_ELEM - 2);

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]  mem [N_ELEM];
  logic [IW-1:0] ld_idx;
  logic [IW-1:0] j;
  logic [IW-1:0] pass;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] j_nx1;
  logic [IW-1:0] j_end;
  logic          swapped;
  logic          swapped_nx;
  logic          pass_end;
  logic          sort_done;

  always_comb begin
    j_nx1      = j + 1'b1;
    j_end      = LASTP - pass;
    swapped_nx = swapped | cmp_lt;
    pass_end   = (j == j_end);
    // final compare's swap counts toward the early-exit decision
    sort_done  = pass_end && (!swapped_nx || pass == LASTP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    cmp_a     = '0;
    cmp_b     = '0;
    busy      = 1'b0;
    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && ld_idx == LAST) begin
          state_nx = SORT;
        end
      end
      SORT: begin
        busy  = 1'b1;
        cmp_a = mem[j_nx1];
        cmp_b = mem[j];
        if (sort_done) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = mem[rd_idx];
        if (out_ready && rd_idx == LAST) begin
          state_nx = LOAD;
        end
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_idx  <= '0;
      j       <= '0;
      pass    <= '0;
      rd_idx  <= '0;
      swapped <= 1'b0;
      for (int i = 0; i < N_ELEM; i++) begin
        mem[i] <= '0;
      end
    end else begin
      unique case (state)
        LOAD: begin
          if (in_valid) begin
            mem[ld_idx] <= in_data;
            if (ld_idx == LAST) begin
              ld_idx  <= '0;
              j       <= '0;
              pass    <= '0;
              swapped <= 1'b0;
            end else begin
              ld_idx <= ld_idx + 1'b1;
            end
          end
        end
        SORT: begin
          if (cmp_lt) begin
            mem[j]     <= mem[j_nx1];
            mem[j_nx1] <= mem[j];
          end
          if (pass_end) begin
            j       <= '0;
            swapped <= 1'b0;
            if (sort_done) begin
              rd_idx <= '0;
            end else begin
              pass <= pass + 1'b1;
            end
          end else begin
            j       <= j_nx1;
            swapped <= swapped_nx;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd_idx == LAST) begin
              rd_idx <= '0;
            end else begin
              rd_idx <= rd_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_sorter.sv
// tb_nibble_sorter: directed vector table plus hand-written sequences
// for backpressure, mid-sort reset and junk input while busy.
module tb_nibble_sorter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [3:0] cmp_a;
  logic [3:0] cmp_b;
  logic       cmp_lt;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  nibble_sorter #(.N_ELEM(4), .W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_lt    (cmp_lt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign cmp_lt = (cmp_a < cmp_b);

  typedef struct {
    logic [15:0] vals;
    logic [15:0] exp;
    int          sort_cyc;
    bit          junk;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_sort(input vec_t v, input string tag);
    int n;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = v.vals[4*k +: 4];
      chk({tag, " in_ready load"}, int'(in_ready), 1);
      tick();
    end
    in_valid = v.junk;
    in_data  = 4'hA;
    n = 0;
    while (busy && !out_valid && n < 50) begin
      if (v.junk) begin
        chk({tag, " in_ready busy"}, int'(in_ready), 0);
      end
      n++;
      in_data = in_data + 4'd3;
      tick();
    end
    chk({tag, " sort cycles"}, n, v.sort_cyc);
  endtask

  task automatic drain_all(input vec_t v, input string tag);
    for (int k = 0; k < 4; k++) begin
      chk({tag, " out_valid"}, int'(out_valid), 1);
      chk({tag, $sformatf(" out_data[%0d]", k)}, int'(out_data),
          int'(v.exp[4*k +: 4]));
      out_ready = 1'b1;
      if (v.junk) in_data = in_data + 4'd5;
      tick();
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, " in_ready after"}, int'(in_ready), 1);
    chk({tag, " out_valid after"}, int'(out_valid), 0);
    chk({tag, " out_data after"}, int'(out_data), 0);
    chk({tag, " busy after"}, int'(busy), 0);
  endtask

  initial begin
    int   pat[7];
    int   hs;
    vec_t v;

    // vals/exp packed element 0 in the low nibble
    tbl[0] = '{vals: 16'h0213, exp: 16'h3210, sort_cyc: 6, junk: 1'b0};
    tbl[1] = '{vals: 16'h4321, exp: 16'h4321, sort_cyc: 3, junk: 1'b0};
    tbl[2] = '{vals: 16'h5255, exp: 16'h5552, sort_cyc: 6, junk: 1'b0};
    tbl[3] = '{vals: 16'h3F07, exp: 16'hF730, sort_cyc: 6, junk: 1'b1};
    pat = '{1, 0, 0, 1, 1, 0, 1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    chk("rst in_ready", int'(in_ready), 1);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_data", int'(out_data), 0);
    chk("rst cmp_a", int'(cmp_a), 0);
    chk("rst cmp_b", int'(cmp_b), 0);
    chk("rst busy", int'(busy), 0);
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 4; t++) begin
      load_sort(tbl[t], $sformatf("vec%0d", t));
      drain_all(tbl[t], $sformatf("vec%0d", t));
    end

    v = '{vals: 16'h1234, exp: 16'h4321, sort_cyc: 6, junk: 1'b0};
    load_sort(v, "bp");
    hs = 0;
    for (int i = 0; i < 7; i++) begin
      if (hs < 4) begin
        chk($sformatf("bp out_valid c%0d", i), int'(out_valid), 1);
        chk($sformatf("bp out_data c%0d", i), int'(out_data),
            int'(v.exp[4*hs +: 4]));
      end
      out_ready = pat[i][0];
      if (out_ready && out_valid) hs++;
      tick();
    end
    out_ready = 1'b0;
    chk("bp handshakes", hs, 4);
    chk("bp in_ready", int'(in_ready), 1);
    chk("bp out_valid end", int'(out_valid), 0);

    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = tbl[0].vals[4*k +: 4];
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid rst in_ready", int'(in_ready), 1);
    chk("mid rst out_valid", int'(out_valid), 0);
    chk("mid rst out_data", int'(out_data), 0);
    chk("mid rst cmp_a", int'(cmp_a), 0);
    chk("mid rst cmp_b", int'(cmp_b), 0);
    chk("mid rst busy", int'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();
    v = '{vals: 16'h6789, exp: 16'h9876, sort_cyc: 6, junk: 1'b0};
    load_sort(v, "post");
    drain_all(v, "post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
